shake256_squeeze_ctrl: RTL and testbench

Sequencer that drives the shared Keccak-f[1600] permutation core for SHAKE256 over the ML-DSA seed rho. It builds the single padded absorb block, starts the permutation and streams squeezed rate words to a downstream consumer. When the requested output exceeds one rate block, it re-permutes the state for each further block. It sits between the key-generation FSM, which issues start, and the Keccak core, which is shared through its start/done pair.

---
 rtl/shake256_squeeze_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_shake256_squeeze_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shake256_squeeze_ctrl.sv
// SHAKE256 sequencer for the ML-DSA seed rho.
// Builds the single padded absorb block, drives the shared Keccak-f[1600]
// core through its start/done pair and streams squeezed 64-bit rate words
// to a valid/ready consumer. It re-permutes the state for every further
// rate block (17 words) that the requested length needs.
module shake256_squeeze_ctrl #(
    parameter int WORD_W = 64,
    parameter int LEN_W  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [511:0]      rho,
    input  logic [1:0]        ml_dsa_level,
    input  logic [LEN_W-1:0]  out_len,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              perm_start,
    output logic [1599:0]     perm_in,
    input  logic [1599:0]     perm_out,
    input  logic              perm_done,
    output logic [WORD_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready
);

    // Index of the last word in one 1088-bit rate block.
    localparam logic [4:0] LAST_RATE_WORD = 5'd16;

    typedef enum logic [2:0] {
        IDLE,
        ABSORB,
        WAIT,
        SQUEEZE,
        DONE
    } fsm_t;

    fsm_t               fsm_q, fsm_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               perm_start_q, perm_start_d;
    logic [1599:0]      perm_in_q, perm_in_d;
    logic [1599:0]      keccak_q, keccak_d;
    logic [WORD_W-1:0]  dout_q, dout_d;
    logic               dout_valid_q, dout_valid_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   emitted_q, emitted_d;
    logic [4:0]         w_q, w_d;
    logic [LEN_W-1:0]   emitted_inc;

    // Padded single absorb block: rho bytes from the top, the SHAKE domain
    // byte 0x1F right below them, the final pad bit 0x80 as the last rate
    // byte and an all-zero capacity.
    function automatic logic [1599:0] pad_block(input logic [511:0] seed,
                                                input logic [1:0]   level);
        logic [1599:0] blk;
        blk = '0;
        case (level)
            2'd0: begin
                blk[1599:1344] = seed[511:256];
                blk[1343:1336] = 8'h1F;
            end
            2'd1: begin
                blk[1599:1216] = seed[511:128];
                blk[1215:1208] = 8'h1F;
            end
            2'd2: begin
                blk[1599:1088] = seed;
                blk[1087:1080] = 8'h1F;
            end
            default: blk = '0;
        endcase
        blk[519:512] = 8'h80;
        return blk;
    endfunction

    // Rate word idx of the state; word 0 is the most significant word.
    function automatic logic [WORD_W-1:0] rate_word(input logic [1599:0] s,
                                                    input logic [4:0]    idx);
        logic [10:0] base;
        base = 11'd1599 - {idx, 6'd0};
        return s[base -: WORD_W];
    endfunction

    // Next-state and next-output logic for the whole sequencer.
    always_comb begin
        fsm_d        = fsm_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        perm_start_d = 1'b0;
        perm_in_d    = perm_in_q;
        keccak_d     = keccak_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        len_d        = len_q;
        emitted_d    = emitted_q;
        w_d          = w_q;
        emitted_inc  = emitted_q + LEN_W'(1);

        case (fsm_q)
            IDLE: begin
                if (start) begin
                    if (ml_dsa_level == 2'd3) begin
                        err_d = 1'b1;
                    end else if (out_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        len_d     = out_len;
                        emitted_d = '0;
                        w_d       = '0;
                        perm_in_d = pad_block(rho, ml_dsa_level);
                        busy_d    = 1'b1;
                        fsm_d     = ABSORB;
                    end
                end
            end

            ABSORB: begin
                perm_start_d = 1'b1;
                fsm_d        = WAIT;
            end

            WAIT: begin
                if (perm_done) begin
                    keccak_d = perm_out;
                    w_d      = '0;
                    fsm_d    = SQUEEZE;
                end
            end

            SQUEEZE: begin
                if (!dout_valid_q) begin
                    // First word of a freshly permuted block.
                    dout_d       = rate_word(keccak_q, w_q);
                    dout_valid_d = 1'b1;
                end else if (dout_ready) begin
                    emitted_d = emitted_inc;
                    if (emitted_inc == len_q) begin
                        // Done pulse and busy drop land right after the last handshake.
                        dout_valid_d = 1'b0;
                        done_d       = 1'b1;
                        busy_d       = 1'b0;
                        fsm_d        = DONE;
                    end else if (w_q == LAST_RATE_WORD) begin
                        dout_valid_d = 1'b0;
                        perm_in_d    = keccak_q;
                        w_d          = '0;
                        fsm_d        = ABSORB;
                    end else begin
                        w_d    = w_q + 5'd1;
                        dout_d = rate_word(keccak_q, w_q + 5'd1);
                    end
                end
            end

            DONE: begin
                fsm_d = IDLE;
            end

            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

    // State and registered outputs, cleared asynchronously by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q        <= IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            perm_start_q <= 1'b0;
            perm_in_q    <= '0;
            keccak_q     <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            len_q        <= '0;
            emitted_q    <= '0;
            w_q          <= '0;
        end else begin
            fsm_q        <= fsm_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            perm_start_q <= perm_start_d;
            perm_in_q    <= perm_in_d;
            keccak_q     <= keccak_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            len_q        <= len_d;
            emitted_q    <= emitted_d;
            w_q          <= w_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign perm_start = perm_start_q;
    assign perm_in    = perm_in_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_shake256_squeeze_ctrl.sv
// Directed bench for shake256_squeeze_ctrl with a behavioural Keccak core
// stand-in (identity or bitwise inversion, fixed 5-cycle latency).
module tb_shake256_squeeze_ctrl;

    localparam int WORD_W = 64;
    localparam int LEN_W  = 10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [511:0]      rho = '0;
    logic [1:0]        ml_dsa_level = 2'd0;
    logic [LEN_W-1:0]  out_len = '0;
    logic              busy;
    logic              done;
    logic              err;
    logic              perm_start;
    logic [1599:0]     perm_in;
    logic [1599:0]     perm_out;
    logic              perm_done;
    logic [WORD_W-1:0] dout;
    logic              dout_valid;
    logic              dout_ready = 1'b1;

    shake256_squeeze_ctrl #(.WORD_W(WORD_W), .LEN_W(LEN_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .rho          (rho),
        .ml_dsa_level (ml_dsa_level),
        .out_len      (out_len),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .perm_start   (perm_start),
        .perm_in      (perm_in),
        .perm_out     (perm_out),
        .perm_done    (perm_done),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .dout_ready   (dout_ready)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // Core stand-in: perm_done is sampled five edges after perm_start is sampled.
    logic [1599:0] core_in;
    logic [3:0]    core_cnt;
    logic          core_done_q;
    logic          core_inv = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_cnt    <= '0;
            core_done_q <= 1'b0;
            core_in     <= '0;
        end else begin
            core_done_q <= (core_cnt == 4'd1);
            if (perm_start) begin
                core_cnt <= 4'd4;
                core_in  <= perm_in;
            end else if (core_cnt != 4'd0) begin
                core_cnt <= core_cnt - 4'd1;
            end
        end
    end

    assign perm_done = core_done_q;
    assign perm_out  = core_done_q ? (core_inv ? ~core_in : core_in) : '0;

    // Event monitor: records handshakes, pulses and dout stability at each edge.
    int            cyc = 0;
    int            hs_cnt = 0;
    int            done_cnt = 0;
    int            err_cnt = 0;
    int            pstart_cnt = 0;
    int            stab_err = 0;
    int            last_hs_cyc = 0;
    int            done_cyc = 0;
    logic [63:0]   words [0:127];
    logic [1599:0] pstart_in [0:15];
    logic          dv_at_pstart [0:15];
    logic          prev_valid = 1'b0;
    logic          prev_ready = 1'b0;
    logic [63:0]   prev_dout = '0;

    always @(posedge clk) begin
        if (dout_valid && dout_ready) begin
            if (hs_cnt < 128) words[hs_cnt] = dout;
            hs_cnt = hs_cnt + 1;
            last_hs_cyc = cyc;
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (err) err_cnt = err_cnt + 1;
        if (perm_start) begin
            if (pstart_cnt < 16) begin
                pstart_in[pstart_cnt]    = perm_in;
                dv_at_pstart[pstart_cnt] = dout_valid;
            end
            pstart_cnt = pstart_cnt + 1;
        end
        if (prev_valid && !prev_ready && (!dout_valid || dout !== prev_dout))
            stab_err = stab_err + 1;
        prev_valid = dout_valid;
        prev_ready = dout_ready;
        prev_dout  = dout;
        cyc = cyc + 1;
    end

    int checks = 0;
    int failures = 0;
    int hs_base, done_base, err_base, ps_base, stab_base;

    localparam logic [511:0] RHO_B = {
        64'h0123456789ABCDEF, 64'hFEDCBA9876543210,
        64'h0F1E2D3C4B5A6978, 64'h8796A5B4C3D2E1F0,
        64'hDEADBEEFCAFEF00D, 64'h0011223344556677,
        64'h8899AABBCCDDEEFF, 64'h13579BDF2468ACE0
    };

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] lvl, input logic [511:0] r, input int len);
        hs_base   = hs_cnt;
        done_base = done_cnt;
        err_base  = err_cnt;
        ps_base   = pstart_cnt;
        stab_base = stab_err;
        ml_dsa_level = lvl;
        rho          = r;
        out_len      = LEN_W'(len);
        start        = 1'b1;
        tick();
        start        = 1'b0;
    endtask

    task automatic waitDone(input bit toggle);
        for (int i = 0; i < 300; i++) begin
            if (done_cnt != done_base) break;
            tick();
            if (toggle) dout_ready = !dout_ready;
        end
        tick();
        tick();
        dout_ready = 1'b1;
        checkOutput("done_once", 64'(done_cnt - done_base), 64'd1);
    endtask

    function automatic logic [63:0] word_at(input int i);
        return words[hs_base + i];
    endfunction

    logic [1599:0] rest;

    initial begin
        // Reset values while rst_n is low.
        #2;
        checkOutput("reset_flags", {59'd0, busy, done, err, perm_start, dout_valid}, 64'd0);
        checkOutput("reset_dout", dout, 64'd0);
        checkOutput("reset_perm_in", {63'd0, |perm_in}, 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Level 0, identity core, 4 words.
        $display("[TB] level 0 job, out_len=4");
        core_inv = 1'b0;
        applyStimulus(2'd0, {256'd0, {4{64'hA5A5A5A5A5A5A5A5}}}, 4);
        checkOutput("a_busy", {63'd0, busy}, 64'd1);
        checkOutput("a_pin_word0", perm_in[1599:1536], 64'd0);
        checkOutput("a_pin_dsbyte", perm_in[1343:1280], 64'h1F00000000000000);
        checkOutput("a_pin_lastrate", perm_in[575:512], 64'h0000000000000080);
        rest = perm_in;
        rest[1343:1336] = 8'h00;
        rest[519:512]   = 8'h00;
        checkOutput("a_pin_rest_zero", {63'd0, |rest}, 64'd0);
        repeat (7) tick();
        checkOutput("a_valid_before_lat", {63'd0, dout_valid}, 64'd0);
        tick();
        checkOutput("a_valid_at_lat", {63'd0, dout_valid}, 64'd1);
        waitDone(1'b0);
        checkOutput("a_handshakes", 64'(hs_cnt - hs_base), 64'd4);
        checkOutput("a_word0", word_at(0), 64'd0);
        checkOutput("a_word3", word_at(3), 64'd0);
        checkOutput("a_pstarts", 64'(pstart_cnt - ps_base), 64'd1);
        checkOutput("a_done_delay", 64'(done_cyc - last_hs_cyc), 64'd1);
        checkOutput("a_busy_after", {63'd0, busy}, 64'd0);

        // Level 2, inverting core, exactly one rate block.
        $display("[TB] level 2 job, out_len=17");
        core_inv = 1'b1;
        applyStimulus(2'd2, RHO_B, 17);
        waitDone(1'b0);
        checkOutput("b_pstarts", 64'(pstart_cnt - ps_base), 64'd1);
        checkOutput("b_handshakes", 64'(hs_cnt - hs_base), 64'd17);
        checkOutput("b_word0", word_at(0), 64'hFEDCBA9876543210);
        checkOutput("b_word1", word_at(1), 64'h0123456789ABCDEF);
        checkOutput("b_word4", word_at(4), 64'h2152411035010FF2);
        checkOutput("b_word7", word_at(7), 64'hECA86420DB97531F);
        checkOutput("b_word8", word_at(8), 64'hE0FFFFFFFFFFFFFF);
        checkOutput("b_word12", word_at(12), 64'hFFFFFFFFFFFFFFFF);
        checkOutput("b_word16", word_at(16), 64'hFFFFFFFFFFFFFF7F);

        // Level 1, 18 words: crosses into a second permutation.
        $display("[TB] level 1 job, out_len=18");
        applyStimulus(2'd1, RHO_B, 18);
        waitDone(1'b0);
        checkOutput("c_pstarts", 64'(pstart_cnt - ps_base), 64'd2);
        checkOutput("c_handshakes", 64'(hs_cnt - hs_base), 64'd18);
        checkOutput("c_word5", word_at(5), 64'hFFEEDDCCBBAA9988);
        checkOutput("c_word6", word_at(6), 64'hE0FFFFFFFFFFFFFF);
        checkOutput("c_word7", word_at(7), 64'hFFFFFFFFFFFFFFFF);
        checkOutput("c_word16", word_at(16), 64'hFFFFFFFFFFFFFF7F);
        checkOutput("c_word17", word_at(17), 64'h0123456789ABCDEF);
        checkOutput("c_repin_top", pstart_in[ps_base + 1][1599:1536], 64'hFEDCBA9876543210);
        checkOutput("c_repin_cap", pstart_in[ps_base + 1][63:0], 64'hFFFFFFFFFFFFFFFF);
        checkOutput("c_valid_in_reperm", {63'd0, dv_at_pstart[ps_base + 1]}, 64'd0);

        // Backpressure: ready toggles every cycle.
        $display("[TB] backpressure job, out_len=5");
        applyStimulus(2'd2, RHO_B, 5);
        waitDone(1'b1);
        checkOutput("d_handshakes", 64'(hs_cnt - hs_base), 64'd5);
        checkOutput("d_stability", 64'(stab_err - stab_base), 64'd0);
        checkOutput("d_word0", word_at(0), 64'hFEDCBA9876543210);
        checkOutput("d_word4", word_at(4), 64'h2152411035010FF2);

        // Reserved level and zero-length requests.
        $display("[TB] reserved level and zero length");
        applyStimulus(2'd3, RHO_B, 4);
        checkOutput("e_err_pulse", {62'd0, err, busy}, 64'd2);
        tick();
        checkOutput("e_err_cleared", {63'd0, err}, 64'd0);
        tick();
        checkOutput("e_err_pstarts", 64'(pstart_cnt - ps_base), 64'd0);
        checkOutput("e_err_count", 64'(err_cnt - err_base), 64'd1);
        applyStimulus(2'd0, RHO_B, 0);
        checkOutput("e_zero_done", {62'd0, done, busy}, 64'd2);
        tick();
        tick();
        checkOutput("e_zero_pstarts", 64'(pstart_cnt - ps_base), 64'd0);
        checkOutput("e_zero_done_count", 64'(done_cnt - done_base), 64'd1);

        // Asynchronous reset while waiting on the core, then a clean job.
        $display("[TB] reset during WAIT");
        applyStimulus(2'd2, RHO_B, 8);
        tick();
        checkOutput("f_pstart_before_rst", {62'd0, perm_start, busy}, 64'd3);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("f_async_clear", {61'd0, busy, dout_valid, perm_start}, 64'd0);
        checkOutput("f_perm_in_clear", {63'd0, |perm_in}, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        applyStimulus(2'd0, RHO_B, 6);
        waitDone(1'b0);
        checkOutput("f_handshakes", 64'(hs_cnt - hs_base), 64'd6);
        checkOutput("f_pstarts", 64'(pstart_cnt - ps_base), 64'd1);
        checkOutput("f_word0", word_at(0), 64'hFEDCBA9876543210);
        checkOutput("f_word3", word_at(3), 64'h78695A4B3C2D1E0F);
        checkOutput("f_word4", word_at(4), 64'hE0FFFFFFFFFFFFFF);
        checkOutput("f_word5", word_at(5), 64'hFFFFFFFFFFFFFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
